// File: rtl/dcache_ahb_sram_slave.sv
// dcache_ahb_sram_slave
//   AHB-Lite single-port SRAM slave behind the dcache AHB master. It serves single
//   NONSEQ/SEQ read and write transfers with WAIT_STATES wait cycles per OKAY data
//   phase, and gives a two-cycle ERROR response to illegal accesses.
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   hsel         slave select
//   haddr        byte address (address phase)
//   htrans       transfer type; htrans[1] marks NONSEQ/SEQ
//   hwrite       1 = write
//   hsize        0 byte, 1 half, 2 word
//   hburst       unused (every transfer is SINGLE)
//   hprot        unused
//   hwdata       write data (data phase)
//   hready       bus ready; the address phase is sampled only while it is high
//   hreadyout    slave ready / data phase complete
//   hresp        0 OKAY, 1 ERROR
//   hrdata       read data, valid in the final read data-phase cycle, else 0
module dcache_ahb_sram_slave #(
  parameter int unsigned                WORD_SIZE   = 32,
  parameter int unsigned                ADDR_LENGTH = 32,
  parameter int unsigned                MEM_BYTES   = 16384,
  parameter logic [ADDR_LENGTH-1:0]     BASE_ADDR   = '0,
  parameter int unsigned                WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hsel,
  input  logic [ADDR_LENGTH-1:0] haddr,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic [2:0]             hburst,
  input  logic [3:0]             hprot,
  input  logic [WORD_SIZE-1:0]   hwdata,
  input  logic                   hready,
  output logic                   hreadyout,
  output logic                   hresp,
  output logic [WORD_SIZE-1:0]   hrdata
);

  localparam int unsigned WORD_BYTES = WORD_SIZE / 8;
  localparam int unsigned OFF_W      = $clog2(WORD_BYTES);
  localparam int unsigned MEM_WORDS  = MEM_BYTES / WORD_BYTES;
  localparam int unsigned IDX_W      = $clog2(MEM_WORDS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]             r_state;
  logic [3:0]             r_wait_cnt;
  logic [ADDR_LENGTH-1:0] r_addr;
  logic                   r_write;
  logic [2:0]             r_size;
  logic                   r_hreadyout;
  logic                   r_hresp;
  logic [WORD_SIZE-1:0]   r_mem [MEM_WORDS];

  logic [2:0]             w_next_state;
  logic [3:0]             w_next_cnt;
  logic                   w_next_hreadyout;
  logic                   w_next_hresp;
  logic                   w_accept;
  logic                   w_illegal;
  logic [ADDR_LENGTH-1:0] w_rel_in;
  logic [ADDR_LENGTH-1:0] w_align_mask;
  logic [IDX_W-1:0]       w_idx;
  logic [OFF_W-1:0]       w_lane_off;
  logic [WORD_BYTES-1:0]  w_byte_en;
  logic                   w_unused_ok;

  assign w_unused_ok = ^{hburst, hprot};

  // A new address phase is taken only while this slave is driving hreadyout high.
  assign w_accept = hsel && hready && htrans[1] &&
                    ((r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2));

  // Legality of the incoming address phase.
  assign w_rel_in     = haddr - BASE_ADDR;
  assign w_align_mask = (ADDR_LENGTH'(1) << hsize) - ADDR_LENGTH'(1);
  assign w_illegal    = (haddr < BASE_ADDR) ||
                        (w_rel_in >= ADDR_LENGTH'(MEM_BYTES)) ||
                        (hsize > 3'(OFF_W)) ||
                        ((haddr & w_align_mask) != '0);

  // Next state, wait counter and the registered response outputs.
  always_comb begin
    w_next_state = S_IDLE;
    w_next_cnt   = r_wait_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_next_state = S_DATA;
        end else begin
          w_next_state = S_WAIT;
          w_next_cnt   = r_wait_cnt - 4'd1;
        end
      end
      S_ERR1: w_next_state = S_ERR2;
      default: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_next_state = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_next_state = S_WAIT;
            w_next_cnt   = 4'(WAIT_STATES - 1);
          end else begin
            w_next_state = S_DATA;
          end
        end
      end
    endcase
    w_next_hreadyout = !((w_next_state == S_WAIT) || (w_next_state == S_ERR1));
    w_next_hresp     = (w_next_state == S_ERR1) || (w_next_state == S_ERR2);
  end

  // State, counter, captured address phase and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_wait_cnt  <= w_next_cnt;
      r_hreadyout <= w_next_hreadyout;
      r_hresp     <= w_next_hresp;
      if (w_accept) begin
        r_addr  <= haddr;
        r_write <= hwrite;
        r_size  <= hsize;
      end
    end
  end

  assign w_idx      = IDX_W'((r_addr - BASE_ADDR) >> OFF_W);
  assign w_lane_off = r_addr[OFF_W-1:0];

  // Little-endian lane select: lanes sharing the aligned 2**size group of the offset.
  always_comb begin
    w_byte_en = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      w_byte_en[b] = ((OFF_W'(b) >> r_size) == (w_lane_off >> r_size));
    end
  end

  // Write commits on the edge that ends DATA; reset forces IDLE so a pending write drops.
  always_ff @(posedge clk) begin
    if ((r_state == S_DATA) && r_write) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (w_byte_en[b]) begin
          r_mem[w_idx][b*8 +: 8] <= hwdata[b*8 +: 8];
        end
      end
    end
  end

  // Read data straight from the array so a back-to-back read sees the write just committed.
  assign hrdata    = ((r_state == S_DATA) && !r_write) ? r_mem[w_idx] : '0;
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;

endmodule

// File: tb/tb_dcache_ahb_sram_slave.sv
// Directed bench: u_dut1 has one wait state, u_dut0 has none. Expected responses are
// queued when an address phase is driven and compared when its data phase completes.
module tb_dcache_ahb_sram_slave;

  localparam int WS1 = 1;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        hsel1, hwrite1, hready1;
  logic [31:0] haddr1, hwdata1;
  logic [1:0]  htrans1;
  logic [2:0]  hsize1, hburst1;
  logic [3:0]  hprot1;
  logic        hreadyout1, hresp1;
  logic [31:0] hrdata1;

  logic        hsel0, hwrite0, hready0;
  logic [31:0] haddr0, hwdata0;
  logic [1:0]  htrans0;
  logic [2:0]  hsize0, hburst0;
  logic [3:0]  hprot0;
  logic        hreadyout0, hresp0;
  logic [31:0] hrdata0;

  dcache_ahb_sram_slave #(.WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel1), .haddr(haddr1), .htrans(htrans1),
    .hwrite(hwrite1), .hsize(hsize1), .hburst(hburst1), .hprot(hprot1),
    .hwdata(hwdata1), .hready(hready1), .hreadyout(hreadyout1), .hresp(hresp1),
    .hrdata(hrdata1)
  );

  dcache_ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel0), .haddr(haddr0), .htrans(htrans0),
    .hwrite(hwrite0), .hsize(hsize0), .hburst(hburst0), .hprot(hprot0),
    .hwdata(hwdata0), .hready(hready0), .hreadyout(hreadyout0), .hresp(hresp0),
    .hrdata(hrdata0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One non-pipelined transfer on u_dut1, checked against the queued expectation.
  task automatic ahb1(input string tag, input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input logic err, input logic [31:0] rd);
    exp_t e;
    exp_t q;
    int   stalls;
    bit   done;
    bit   resp_ok;
    e.tag    = tag;
    e.err    = err;
    e.rdata  = (w || err) ? 32'h0 : rd;
    e.stalls = err ? 1 : WS1;
    sb.push_back(e);
    @(negedge clk);
    hsel1 = 1'b1; haddr1 = a; htrans1 = 2'b10; hwrite1 = w; hsize1 = sz;
    @(posedge clk);
    #1;
    hsel1 = 1'b0; htrans1 = 2'b00; hwdata1 = wd;
    stalls  = 0;
    done    = 1'b0;
    resp_ok = 1'b1;
    while (!done && stalls < 16) begin
      @(negedge clk);
      if (hresp1 !== err) resp_ok = 1'b0;
      if (hreadyout1 === 1'b1) done = 1'b1;
      else stalls++;
    end
    q = sb.pop_front();
    check({q.tag, " done"},   32'(done), 32'd1);
    check({q.tag, " stalls"}, 32'(stalls), 32'(q.stalls));
    check({q.tag, " hresp"},  32'(resp_ok), 32'd1);
    check({q.tag, " hrdata"}, hrdata1, q.rdata);
  endtask

  initial begin
    exp_t e;
    hsel1 = 0; haddr1 = 0; htrans1 = 0; hwrite1 = 0; hsize1 = 0; hburst1 = 0;
    hprot1 = 0; hwdata1 = 0; hready1 = 1;
    hsel0 = 0; haddr0 = 0; htrans0 = 0; hwrite0 = 0; hsize0 = 0; hburst0 = 0;
    hprot0 = 0; hwdata0 = 0; hready0 = 1;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset hreadyout", 32'(hreadyout1), 32'd1);
    check("reset hresp",     32'(hresp1),     32'd0);
    check("reset hrdata",    hrdata1,         32'h0);
    rst_n = 1'b1;

    // 1: word write then read with one wait state
    ahb1("t1 wr", 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
    ahb1("t1 rd", 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);

    // 2: byte and halfword lane merges
    ahb1("t2 wr word", 32'h10, 1'b1, 3'd2, 32'h11223344, 1'b0, 32'h0);
    ahb1("t2 wr byte", 32'h13, 1'b1, 3'd0, 32'hAA000000, 1'b0, 32'h0);
    ahb1("t2 wr half", 32'h10, 1'b1, 3'd1, 32'h00005566, 1'b0, 32'h0);
    ahb1("t2 rd",      32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hAA225566);

    // Last word of the array is legal
    ahb1("top wr", 32'h3FFC, 1'b1, 3'd2, 32'h0BADCAFE, 1'b0, 32'h0);
    ahb1("top rd", 32'h3FFC, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0BADCAFE);

    // 3: one past the end is an ERROR, followed by an IDLE OKAY
    ahb1("t3 oob", 32'h4000, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    check("t3 idle hreadyout", 32'(hreadyout1), 32'd1);
    check("t3 idle hresp",     32'(hresp1),     32'd0);

    // 4: misaligned half write and oversize read both ERROR, memory untouched
    ahb1("t4 wr 0", 32'h0, 1'b1, 3'd2, 32'h01020304, 1'b0, 32'h0);
    ahb1("t4 misalign", 32'h11, 1'b1, 3'd1, 32'hFFFFFFFF, 1'b1, 32'h0);
    ahb1("t4 hsize3",   32'h0,  1'b0, 3'd3, 32'h0, 1'b1, 32'h0);
    ahb1("t4 rd 10", 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hAA225566);
    ahb1("t4 rd 0",  32'h0,  1'b0, 3'd2, 32'h0, 1'b0, 32'h01020304);

    // Address phase with hready low must be ignored
    @(negedge clk);
    hsel1 = 1'b1; haddr1 = 32'h10; htrans1 = 2'b10; hwrite1 = 1'b0; hsize1 = 3'd2;
    hready1 = 1'b0;
    @(posedge clk);
    #1;
    hsel1 = 1'b0; htrans1 = 2'b00; hready1 = 1'b1;
    @(negedge clk);
    check("hready low ignored", 32'(hreadyout1), 32'd1);
    check("hready low hrdata",  hrdata1, 32'h0);

    // Selected with BUSY: zero-wait OKAY
    @(negedge clk);
    hsel1 = 1'b1; htrans1 = 2'b01;
    @(posedge clk);
    #1;
    hsel1 = 1'b0; htrans1 = 2'b00;
    @(negedge clk);
    check("busy hreadyout", 32'(hreadyout1), 32'd1);
    check("busy hresp",     32'(hresp1),     32'd0);

    // 5: zero wait states, pipelined write then read of the same word
    @(negedge clk);
    hsel0 = 1'b1; haddr0 = 32'h20; htrans0 = 2'b10; hwrite0 = 1'b1; hsize0 = 3'd2;
    e.tag = "t5 wr"; e.err = 1'b0; e.rdata = 32'h0; e.stalls = 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    hwrite0 = 1'b0; hwdata0 = 32'hCAFEF00D;
    e.tag = "t5 rd"; e.err = 1'b0; e.rdata = 32'hCAFEF00D; e.stalls = 0;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, " hreadyout"}, 32'(hreadyout0), 32'd1);
    check({e.tag, " hresp"},     32'(hresp0),     32'(e.err));
    check({e.tag, " hrdata"},    hrdata0,         e.rdata);
    @(posedge clk);
    #1;
    hsel0 = 1'b0; htrans0 = 2'b00;
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, " hreadyout"}, 32'(hreadyout0), 32'd1);
    check({e.tag, " hresp"},     32'(hresp0),     32'(e.err));
    check({e.tag, " hrdata"},    hrdata0,         e.rdata);

    // 6: reset during the wait cycle of a write drops it
    ahb1("t6 wr old", 32'h30, 1'b1, 3'd2, 32'h55AA55AA, 1'b0, 32'h0);
    @(negedge clk);
    hsel1 = 1'b1; haddr1 = 32'h30; htrans1 = 2'b10; hwrite1 = 1'b1; hsize1 = 3'd2;
    @(posedge clk);
    #1;
    hsel1 = 1'b0; htrans1 = 2'b00; hwdata1 = 32'h12345678;
    @(negedge clk);
    check("t6 in wait", 32'(hreadyout1), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6 rst hreadyout", 32'(hreadyout1), 32'd1);
    check("t6 rst hresp",     32'(hresp1),     32'd0);
    check("t6 rst hrdata",    hrdata1,         32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ahb1("t6 rd", 32'h30, 1'b0, 3'd2, 32'h0, 1'b0, 32'h55AA55AA);

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
